// File: rtl/ysyx_23060072_mem_resp_pkg.sv
// ysyx_23060072_mem_resp_pkg: shared FSM encoding, counter width and address check
package ysyx_23060072_mem_resp_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  // misaligned or beyond the 2^aw-word array
  function automatic logic addr_err(input logic [31:0] a, input int unsigned aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/ysyx_23060072_sram_array.sv
// ysyx_23060072_sram_array: single-port word array with byte write-enables and registered read data
module ysyx_23060072_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  assign rdata = rdata_q;
  // read data is held until the next read; contents are never reset
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[addr];
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/ysyx_23060072_mem_resp.sv
// ysyx_23060072_mem_resp: single-outstanding memory responder with fixed latency and backpressure
module ysyx_23060072_mem_resp
  import ysyx_23060072_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               err_q, err_d, rd_q, rd_d;
  logic               accept, fire, a_we, a_err;
  logic [31:0]        a_addr, a_wdata, sram_rdata;
  logic [3:0]         a_wstrb;
  assign accept = req_valid_i && req_ready_o;
  assign fire   = (state_d == ST_RESP) && (state_q != ST_RESP);
  // a zero-latency access fires on the accept edge, so it must use the live request
  always_comb begin
    a_addr  = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    a_we    = (state_q == ST_IDLE) ? req_we_i    : we_q;
    a_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;
    a_wstrb = (state_q == ST_IDLE) ? req_wstrb_i : wstrb_q;
    a_err   = addr_err(a_addr, AW);
  end
  // request capture, latency countdown and response flags
  always_comb begin
    addr_d  = accept ? req_addr_i  : addr_q;
    we_d    = accept ? req_we_i    : we_q;
    wdata_d = accept ? req_wdata_i : wdata_q;
    wstrb_d = accept ? req_wstrb_i : wstrb_q;
    cnt_d   = accept ? ((LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1))
            : (state_q == ST_WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    err_d   = fire ? a_err : err_q;
    rd_d    = fire ? (!a_err && !a_we) : rd_q;
  end
  // next state
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (req_valid_i ? ((LATENCY == 0) ? ST_RESP : ST_WAIT) : ST_IDLE)
            : (state_q == ST_WAIT) ? ((cnt_q == '0) ? ST_RESP : ST_WAIT)
            : (rsp_ready_i ? ST_IDLE : ST_RESP);
  end
  // outputs decoded from state and the flags latched on entry to RESP
  always_comb begin
    req_ready_o = state_q == ST_IDLE;
    rsp_valid_o = state_q == ST_RESP;
    rsp_err_o   = err_q;
    rsp_rdata_o = rd_q ? sram_rdata : '0;
  end
  // state and captured request; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end
  ysyx_23060072_sram_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .re    (fire && !a_err && !a_we),
    .be    ((fire && !a_err && a_we) ? a_wstrb : 4'b0000),
    .addr  (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (sram_rdata)
  );
endmodule

// File: tb/tb_ysyx_23060072_mem_resp.sv
// tb_ysyx_23060072_mem_resp: directed and random checks of both latency configurations against a word-array model
module tb_ysyx_23060072_mem_resp;
  logic        clk = 1'b0;
  logic        rst, sel, rv, we, rr;
  logic [31:0] addr, wd;
  logic [3:0]  ws;
  logic        rdy2, val2, err2, rdy0, val0, err0;
  logic [31:0] rd2, rd0;
  logic        ready, valid, err;
  logic [31:0] rdata;
  logic [31:0] m2 [16];
  logic [31:0] m0 [16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_23060072_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(rv & ~sel), .req_ready_o(rdy2), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wd), .req_wstrb_i(ws), .rsp_valid_o(val2),
    .rsp_ready_i(rr), .rsp_rdata_o(rd2), .rsp_err_o(err2));
  ysyx_23060072_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(rv & sel), .req_ready_o(rdy0), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wd), .req_wstrb_i(ws), .rsp_valid_o(val0),
    .rsp_ready_i(rr), .rsp_rdata_o(rd0), .rsp_err_o(err0));

  assign ready = sel ? rdy0 : rdy2;
  assign valid = sel ? val0 : val2;
  assign err   = sel ? err0 : err2;
  assign rdata = sel ? rd0  : rd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one full transaction on the selected DUT, with 'hold' cycles of response backpressure
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    int lat = sel ? 0 : 2;
    int k;
    int idx = int'(a[5:2]);
    logic ee = (a % 4 != 0) || (a / 4 >= 1024);
    logic [31:0] er = 32'h0;
    logic [31:0] old, nw, hr;
    if (!ee) begin
      old = sel ? m0[idx] : m2[idx];
      nw = old;
      for (int i = 0; i < 4; i++) if (s[i]) nw[8*i +: 8] = d[8*i +: 8];
      if (w) begin
        if (sel) m0[idx] = nw; else m2[idx] = nw;
      end else er = old;
    end
    @(negedge clk);
    chk("req_ready_idle", ready, 1);
    rv = 1; we = w; addr = a; wd = d; ws = s; rr = 0;
    @(posedge clk);
    @(negedge clk);
    rv = 0; we = 1'($urandom); addr = $urandom; wd = $urandom; ws = 4'($urandom);
    k = 0;
    while (!valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("rsp_err", err, ee);
    chk("rsp_rdata", rdata, er);
    hr = rdata;
    for (int i = 0; i < hold; i++) begin
      rv = 1;
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_rdata", rdata, hr);
      chk("hold_ready", ready, 0);
    end
    rv = 1; we = 0; rr = 1;
    @(negedge clk);
    chk("release_valid", valid, 0);
    chk("release_ready", ready, 1);
    rv = 0; rr = 0;
    @(negedge clk);
    chk("no_second_accept", {valid, ready}, 2'b01);
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    rst = 1; sel = 0; rv = 0; we = 0; rr = 0; addr = 0; wd = 0; ws = 0;
    #1;
    chk("rst_valid", {val2, val0}, 2'b00);
    chk("rst_err", {err2, err0}, 2'b00);
    chk("rst_rdata2", rd2, 0);
    chk("rst_rdata0", rd0, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ready", {rdy2, rdy0}, 2'b11);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 16; i++) txn(1, 32'(i * 4), $urandom, 4'hF, 0);
    end
    sel = 0;
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 32'h10, 0, 4'h0, 0);
    txn(1, 32'h10, 32'h0000AA00, 4'b0010, 0);
    txn(0, 32'h10, 0, 4'h0, 5);
    chk("merge_model", m2[4], 32'hDEADAAEF);
    txn(0, 32'h13, 0, 4'h0, 0);
    txn(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0);
    txn(0, 32'h0, 0, 4'h0, 0);
    txn(1, 32'h8, 32'hFFFFFFFF, 4'h0, 1);
    txn(0, 32'h8, 0, 4'h0, 0);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 40; i++) begin
        cnt = int'($urandom_range(0, 9));
        a = (cnt < 7) ? 32'($urandom_range(0, 15) * 4)
          : (cnt == 7) ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3))
          : (cnt == 8) ? 32'((1024 + $urandom_range(0, 5000)) * 4) : 32'hFFFFFFF0;
        txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)));
      end
    end
    sel = 1;
    @(negedge clk);
    rv = 1; we = 0; addr = 32'h10; ws = 0; rr = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid) begin
        cnt++;
        chk("b2b_rdata", rdata, m0[4]);
      end
    end
    rv = 0; rr = 0;
    chk("b2b_responses", cnt, 3);
    @(negedge clk);
    sel = 0;
    @(negedge clk);
    rv = 1; we = 1; addr = 32'h20; wd = 32'h12345678; ws = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rv = 0;
    chk("wait_valid", valid, 0);
    #2 rst = 1;
    #1;
    chk("async_rst_ready", ready, 1);
    chk("async_rst_valid", valid, 0);
    @(negedge clk);
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    chk("rst_no_response", cnt, 0);
    txn(0, 32'h20, 0, 4'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
